// File: rtl/midi_decoder_pkg.sv
// Shared MIDI decoder definitions: command codes, FSM states and byte helpers.
// Consumers of the midi_cmd bus compare against the MIDI_CMD_* constants here.
package midi_decoder_pkg;

  localparam int unsigned MIDI_CMD_SIZE = 3;

  localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_NOTE_OFF = 3'd0;
  localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_NOTE_ON  = 3'd1;
  localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_POLY_AT  = 3'd2;
  localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_CC       = 3'd3;
  localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_PROG     = 3'd4;
  localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_CHAN_AT  = 3'd5;
  localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_PITCH    = 3'd6;
  localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_SYS_RT   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_D0,
    ST_WAIT_D1,
    ST_SKIP
  } midi_state_e;

  // Program change and channel aftertouch carry a single data byte.
  function automatic logic midi_is_one_byte(input logic [MIDI_CMD_SIZE-1:0] cmd);
    return (cmd == MIDI_CMD_PROG) || (cmd == MIDI_CMD_CHAN_AT);
  endfunction

  function automatic logic midi_is_realtime(input logic [7:0] b);
    return b[7:3] == 5'b11111;
  endfunction

  function automatic logic midi_is_syscommon(input logic [7:0] b);
    return b[7:3] == 5'b11110;
  endfunction

endpackage

// File: rtl/midi_decoder.sv
// MIDI byte-stream decoder with running status, SysEx/system-common skipping,
// realtime pass-through and an optional single-channel filter.
module midi_decoder
  import midi_decoder_pkg::*;
#(
  parameter logic       OMNI    = 1'b1,
  parameter logic [3:0] CHANNEL = 4'd0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     uart_rx_rdy,
  input  logic [7:0]               uart_rx_data,
  output logic                     midi_rdy,
  output logic [MIDI_CMD_SIZE-1:0] midi_cmd,
  output logic [3:0]               midi_ch_sysn,
  output logic [6:0]               midi_data0,
  output logic [6:0]               midi_data1
);

  midi_state_e              r_state;
  midi_state_e              w_state_nxt;
  logic [MIDI_CMD_SIZE-1:0] r_st_cmd;
  logic [MIDI_CMD_SIZE-1:0] w_st_cmd_nxt;
  logic [3:0]               r_st_chan;
  logic [3:0]               w_st_chan_nxt;
  logic [6:0]               r_data0;
  logic [6:0]               w_data0_nxt;

  logic                     w_emit;
  logic [MIDI_CMD_SIZE-1:0] w_out_cmd;
  logic [3:0]               w_out_ch;
  logic [6:0]               w_out_d0;
  logic [6:0]               w_out_d1;
  logic                     w_pass;

  logic                     r_rdy;
  logic [MIDI_CMD_SIZE-1:0] r_cmd;
  logic [3:0]               r_ch;
  logic [6:0]               r_d0;
  logic [6:0]               r_d1;

  assign w_pass = OMNI || (r_st_chan == CHANNEL);

  always_comb begin
    w_state_nxt   = r_state;
    w_st_cmd_nxt  = r_st_cmd;
    w_st_chan_nxt = r_st_chan;
    w_data0_nxt   = r_data0;
    w_emit        = 1'b0;
    w_out_cmd     = '0;
    w_out_ch      = '0;
    w_out_d0      = '0;
    w_out_d1      = '0;

    if (uart_rx_rdy) begin
      if (midi_is_realtime(uart_rx_data)) begin
        // Realtime bytes may arrive mid-message; decoder context is left intact.
        w_emit    = 1'b1;
        w_out_cmd = MIDI_CMD_SYS_RT;
        w_out_ch  = uart_rx_data[3:0];
      end else if (midi_is_syscommon(uart_rx_data)) begin
        w_st_cmd_nxt  = '0;
        w_st_chan_nxt = '0;
        w_state_nxt   = ((uart_rx_data == 8'hF6) || (uart_rx_data == 8'hF7)) ? ST_IDLE : ST_SKIP;
      end else if (uart_rx_data[7]) begin
        w_st_cmd_nxt  = uart_rx_data[6:4];
        w_st_chan_nxt = uart_rx_data[3:0];
        w_state_nxt   = ST_WAIT_D0;
      end else begin
        unique case (r_state)
          ST_WAIT_D0: begin
            if (midi_is_one_byte(r_st_cmd)) begin
              w_emit    = w_pass;
              w_out_cmd = r_st_cmd;
              w_out_ch  = r_st_chan;
              w_out_d0  = uart_rx_data[6:0];
            end else begin
              w_data0_nxt = uart_rx_data[6:0];
              w_state_nxt = ST_WAIT_D1;
            end
          end
          ST_WAIT_D1: begin
            w_emit      = w_pass;
            w_out_cmd   = ((r_st_cmd == MIDI_CMD_NOTE_ON) && (uart_rx_data[6:0] == 7'd0))
                          ? MIDI_CMD_NOTE_OFF : r_st_cmd;
            w_out_ch    = r_st_chan;
            w_out_d0    = r_data0;
            w_out_d1    = uart_rx_data[6:0];
            w_state_nxt = ST_WAIT_D0;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_st_cmd  <= '0;
      r_st_chan <= '0;
      r_data0   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_st_cmd  <= w_st_cmd_nxt;
      r_st_chan <= w_st_chan_nxt;
      r_data0   <= w_data0_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdy <= 1'b0;
      r_cmd <= '0;
      r_ch  <= '0;
      r_d0  <= '0;
      r_d1  <= '0;
    end else begin
      r_rdy <= w_emit;
      if (w_emit) begin
        r_cmd <= w_out_cmd;
        r_ch  <= w_out_ch;
        r_d0  <= w_out_d0;
        r_d1  <= w_out_d1;
      end
    end
  end

  assign midi_rdy     = r_rdy;
  assign midi_cmd     = r_cmd;
  assign midi_ch_sysn = r_ch;
  assign midi_data0   = r_d0;
  assign midi_data1   = r_d1;

endmodule

// File: tb/tb_midi_decoder.sv
// Self-checking bench for midi_decoder: an omni instance and a channel-2 filtered
// instance share one byte stream; expected messages are queued and matched per pulse.
module tb_midi_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_rdy = 1'b0;
  logic [7:0] rx_data = 8'h00;

  logic       rdy1, rdy2;
  logic [2:0] cmd1, cmd2;
  logic [3:0] ch1, ch2;
  logic [6:0] d0_1, d0_2, d1_1, d1_2;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [7:0] b;
    logic       e1;
    logic       e2;
    logic [2:0] cmd;
    logic [3:0] ch;
    logic [6:0] d0;
    logic [6:0] d1;
  } vec_t;

  typedef struct {
    int         due;
    logic [2:0] cmd;
    logic [3:0] ch;
    logic [6:0] d0;
    logic [6:0] d1;
  } exp_t;

  vec_t vecs[$];
  exp_t q1[$];
  exp_t q2[$];
  exp_t last1, last2;

  midi_decoder u_dut (
    .clk(clk), .reset(reset), .uart_rx_rdy(rx_rdy), .uart_rx_data(rx_data),
    .midi_rdy(rdy1), .midi_cmd(cmd1), .midi_ch_sysn(ch1),
    .midi_data0(d0_1), .midi_data1(d1_1)
  );

  midi_decoder #(.OMNI(1'b0), .CHANNEL(4'd2)) u_dut_f (
    .clk(clk), .reset(reset), .uart_rx_rdy(rx_rdy), .uart_rx_data(rx_data),
    .midi_rdy(rdy2), .midi_cmd(cmd2), .midi_ch_sysn(ch2),
    .midi_data0(d0_2), .midi_data1(d1_2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic addn(input logic [7:0] b);
    vec_t v;
    v.b = b; v.e1 = 1'b0; v.e2 = 1'b0; v.cmd = '0; v.ch = '0; v.d0 = '0; v.d1 = '0;
    vecs.push_back(v);
  endtask

  task automatic adde(input logic [7:0] b, input logic e1, input logic e2, input logic [2:0] cmd,
                      input logic [3:0] ch, input logic [6:0] d0, input logic [6:0] d1);
    vec_t v;
    v.b = b; v.e1 = e1; v.e2 = e2; v.cmd = cmd; v.ch = ch; v.d0 = d0; v.d1 = d1;
    vecs.push_back(v);
  endtask

  task automatic send(input vec_t v);
    exp_t e;
    @(posedge clk);
    #1;
    rx_rdy  = 1'b1;
    rx_data = v.b;
    e.due = cyc + 1; e.cmd = v.cmd; e.ch = v.ch; e.d0 = v.d0; e.d1 = v.d1;
    if (v.e1) q1.push_back(e);
    if (v.e2) q2.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      rx_rdy  = 1'b0;
      rx_data = 8'($urandom);
    end
  endtask

  task automatic sendn(input logic [7:0] b);
    vec_t v;
    v.b = b; v.e1 = 1'b0; v.e2 = 1'b0; v.cmd = '0; v.ch = '0; v.d0 = '0; v.d1 = '0;
    send(v);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    rx_rdy = 1'b0;
    reset  = 1'b1;
    idle(2);
    reset = 1'b0;
  endtask

  task automatic mon(input int id, input logic rdy, input logic [2:0] cmd, input logic [3:0] ch,
                     input logic [6:0] d0, input logic [6:0] d1);
    exp_t e, l;
    total++;
    if (rdy) begin
      if ((id == 1 && q1.size() == 0) || (id == 2 && q2.size() == 0)) begin
        bad++;
        $display("FAIL unexpected_pulse dut%0d cyc=%0d got cmd=%0d ch=%h d0=%h d1=%h want no pulse",
                 id, cyc, cmd, ch, d0, d1);
      end else begin
        e = (id == 1) ? q1.pop_front() : q2.pop_front();
        if (e.due != cyc || e.cmd != cmd || e.ch != ch || e.d0 != d0 || e.d1 != d1) begin
          bad++;
          $display("FAIL msg dut%0d got cyc=%0d cmd=%0d ch=%h d0=%h d1=%h want cyc=%0d cmd=%0d ch=%h d0=%h d1=%h",
                   id, cyc, cmd, ch, d0, d1, e.due, e.cmd, e.ch, e.d0, e.d1);
        end
        if (id == 1) last1 = e; else last2 = e;
      end
    end else begin
      l = (id == 1) ? last1 : last2;
      if (l.cmd != cmd || l.ch != ch || l.d0 != d0 || l.d1 != d1) begin
        bad++;
        $display("FAIL hold dut%0d cyc=%0d got cmd=%0d ch=%h d0=%h d1=%h want cmd=%0d ch=%h d0=%h d1=%h",
                 id, cyc, cmd, ch, d0, d1, l.cmd, l.ch, l.d0, l.d1);
      end
      if ((id == 1 && q1.size() != 0 && q1[0].due < cyc) ||
          (id == 2 && q2.size() != 0 && q2[0].due < cyc)) begin
        bad++;
        $display("FAIL missing_pulse dut%0d cyc=%0d got no pulse want pulse", id, cyc);
        if (id == 1) void'(q1.pop_front()); else void'(q2.pop_front());
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      total++;
      if (rdy1 || rdy2 || cmd1 != 0 || ch1 != 0 || d0_1 != 0 || d1_1 != 0 ||
          cmd2 != 0 || ch2 != 0 || d0_2 != 0 || d1_2 != 0) begin
        bad++;
        $display("FAIL reset_outputs got rdy=%b/%b cmd=%0d/%0d ch=%h/%h d0=%h/%h d1=%h/%h want all 0",
                 rdy1, rdy2, cmd1, cmd2, ch1, ch2, d0_1, d0_2, d1_1, d1_2);
      end
      last1 = '{0, 3'd0, 4'd0, 7'd0, 7'd0};
      last2 = '{0, 3'd0, 4'd0, 7'd0, 7'd0};
    end else begin
      mon(1, rdy1, cmd1, ch1, d0_1, d1_1);
      mon(2, rdy2, cmd2, ch2, d0_2, d1_2);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d want finish", cyc);
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin
    // Channel messages and running status
    addn(8'h91); addn(8'h3C); adde(8'h64, 1, 0, 3'd1, 4'h1, 7'h3C, 7'h64);
    addn(8'h40); adde(8'h50, 1, 0, 3'd1, 4'h1, 7'h40, 7'h50);
    addn(8'h3C); adde(8'h00, 1, 0, 3'd0, 4'h1, 7'h3C, 7'h00);
    // Realtime interleaved inside a message
    addn(8'h90); addn(8'h3C); adde(8'hF8, 1, 1, 3'd7, 4'h8, 7'h00, 7'h00);
    adde(8'h7F, 1, 0, 3'd1, 4'h0, 7'h3C, 7'h7F);
    // One-byte messages with running status
    addn(8'hC5); adde(8'h10, 1, 0, 3'd4, 4'h5, 7'h10, 7'h00);
    adde(8'h11, 1, 0, 3'd4, 4'h5, 7'h11, 7'h00);
    // SysEx and orphan data
    addn(8'hF0); addn(8'h01); addn(8'h02); addn(8'hF7); addn(8'h3C); addn(8'h40);
    // Channel filter
    addn(8'h93); addn(8'h3C); adde(8'h40, 1, 0, 3'd1, 4'h3, 7'h3C, 7'h40);
    addn(8'h92); addn(8'h3C); adde(8'h40, 1, 1, 3'd1, 4'h2, 7'h3C, 7'h40);
    addn(8'h3C); adde(8'h00, 1, 1, 3'd0, 4'h2, 7'h3C, 7'h00);
    // New status abandons a partial message
    addn(8'h90); addn(8'h3C); addn(8'hB0); addn(8'h07);
    adde(8'h64, 1, 0, 3'd3, 4'h0, 7'h07, 7'h64);
    addn(8'hE1); addn(8'h00); adde(8'h40, 1, 0, 3'd6, 4'h1, 7'h00, 7'h40);
    // System common then tune request back to idle
    addn(8'hF2); addn(8'h01); addn(8'h02); addn(8'h3C); addn(8'hF6); addn(8'h3C);
    adde(8'hFF, 1, 1, 3'd7, 4'hF, 7'h00, 7'h00);
    // Realtime between one-byte messages, and inside WAIT_D1
    addn(8'hD3); adde(8'h05, 1, 0, 3'd5, 4'h3, 7'h05, 7'h00);
    adde(8'hFE, 1, 1, 3'd7, 4'hE, 7'h00, 7'h00);
    adde(8'h06, 1, 0, 3'd5, 4'h3, 7'h06, 7'h00);
    addn(8'hA2); addn(8'h3C); adde(8'hFA, 1, 1, 3'd7, 4'hA, 7'h00, 7'h00);
    adde(8'h20, 1, 1, 3'd2, 4'h2, 7'h3C, 7'h20);

    last1 = '{0, 3'd0, 4'd0, 7'd0, 7'd0};
    last2 = '{0, 3'd0, 4'd0, 7'd0, 7'd0};
    idle(3);
    reset = 1'b0;
    idle(2);

    for (int i = 0; i < vecs.size(); i++) begin
      send(vecs[i]);
      if (i % 3 == 2) idle(int'($urandom_range(0, 2)));
    end
    idle(4);

    // Reset between status and first data byte
    sendn(8'h90);
    idle(1);
    pulse_reset();
    sendn(8'h3C); sendn(8'h40);
    idle(3);

    // Reset after data0 latched; running status must be gone afterwards
    sendn(8'h91); sendn(8'h3C);
    pulse_reset();
    sendn(8'h40); sendn(8'h3C); sendn(8'h40);
    idle(3);

    // Decoder works again after reset
    begin
      vec_t v;
      sendn(8'h95); sendn(8'h3C);
      v.b = 8'h40; v.e1 = 1'b1; v.e2 = 1'b0; v.cmd = 3'd1; v.ch = 4'h5; v.d0 = 7'h3C; v.d1 = 7'h40;
      send(v);
    end
    idle(5);

    total++;
    if (q1.size() != 0 || q2.size() != 0) begin
      bad++;
      $display("FAIL leftover got q1=%0d q2=%0d want 0 0", q1.size(), q2.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
